wb_stage: RTL and testbench

- Write-back stage between the EX/MEM pipeline register and the register file write port (rd_waddr/rd_wdata/rd_wen).
- Retires one instruction at a time.
  - ALU results: written one cycle after acceptance.
  - Loads: waits for the data-memory response, then aligns and sign/zero-extends it before writing.
- Write outputs are registered. The register file's same-cycle write bypass gives decode the new value in the cycle rd_wen_o is high.

---
 rtl/wb_stage.sv | 176 +++++++++++++++++
 tb/tb_wb_stage.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/wb_stage.sv
// ---------------------------------------------------------------------------
// wb_stage : write-back stage between the EX/MEM register and the register
// file write port. Retires one instruction at a time. ALU results are
// written one cycle after acceptance. Loads wait for the data-memory
// response, then align and extend it before writing. All write outputs are
// registered.
//
// Handshake: an instruction is accepted in any cycle where in_valid_i and
// in_ready_o are both high at the rising clock edge. Upstream must hold its
// inputs stable while in_valid_i is high and in_ready_o is low.
//
// Ports
//   clk, rst            clock (rising edge), asynchronous active-high reset
//   in_valid_i/ready_o  upstream handshake
//   in_rd_addr_i        destination register
//   in_rd_wen_i         instruction writes rd
//   in_is_load_i        instruction is a load
//   in_funct3_i         load type (LB/LH/LW/LBU/LHU)
//   in_addr_lsb_i       load byte address [1:0]
//   in_alu_data_i       ALU result for non-loads
//   mem_rvalid_i        load data valid (one-cycle pulse)
//   mem_rdata_i         raw word from data memory
//   rd_waddr_o/wdata_o  register file write address / data (held)
//   rd_wen_o            register file write enable (pulse)
//   retire_o            pulses for every completed instruction
//   err_o               pulses on a misaligned or illegal load (no write)
//   dbg_state_o         current FSM state, for observation only
// ---------------------------------------------------------------------------
module wb_stage #(
    parameter int DATA_W  = 32,
    parameter int RADDR_W = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid_i,
    output logic               in_ready_o,
    input  logic [RADDR_W-1:0] in_rd_addr_i,
    input  logic               in_rd_wen_i,
    input  logic               in_is_load_i,
    input  logic [2:0]         in_funct3_i,
    input  logic [1:0]         in_addr_lsb_i,
    input  logic [DATA_W-1:0]  in_alu_data_i,
    input  logic               mem_rvalid_i,
    input  logic [DATA_W-1:0]  mem_rdata_i,
    output logic [RADDR_W-1:0] rd_waddr_o,
    output logic [DATA_W-1:0]  rd_wdata_o,
    output logic               rd_wen_o,
    output logic               retire_o,
    output logic               err_o,
    output logic [1:0]         dbg_state_o
);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_WAIT_MEM = 2'd1,
        S_WB       = 2'd2
    } state_t;

    state_t               state_q;
    logic [RADDR_W-1:0]   rd_waddr_q;
    logic [DATA_W-1:0]    rd_wdata_q;
    logic                 rd_wen_q;
    logic                 retire_q;
    logic                 err_q;

    // Load context captured at acceptance, used when the data returns.
    logic [RADDR_W-1:0]   ld_rd_q;
    logic                 ld_wen_q;
    logic [2:0]           ld_funct3_q;
    logic [1:0]           ld_lsb_q;

    logic                 accept;
    logic                 load_illegal;
    logic [7:0]           ld_byte;
    logic [15:0]          ld_half;
    logic [DATA_W-1:0]    ld_data_d;

    assign in_ready_o  = (state_q != S_WAIT_MEM);
    assign accept      = in_valid_i & in_ready_o;
    assign dbg_state_o = state_q;

    // Illegal or misaligned loads are decided from the incoming fields so the
    // error can retire without ever touching memory.
    always_comb begin
        load_illegal = 1'b1;
        case (in_funct3_i)
            3'b000, 3'b100: load_illegal = 1'b0;
            3'b001, 3'b101: load_illegal = in_addr_lsb_i[0];
            3'b010:         load_illegal = (in_addr_lsb_i != 2'b00);
            default:        load_illegal = 1'b1;
        endcase
    end

    // Byte/half selection and extension of the returned word.
    always_comb begin
        ld_byte = mem_rdata_i[7:0];
        case (ld_lsb_q)
            2'd0:    ld_byte = mem_rdata_i[7:0];
            2'd1:    ld_byte = mem_rdata_i[15:8];
            2'd2:    ld_byte = mem_rdata_i[23:16];
            default: ld_byte = mem_rdata_i[31:24];
        endcase
        ld_half = ld_lsb_q[1] ? mem_rdata_i[31:16] : mem_rdata_i[15:0];

        ld_data_d = mem_rdata_i;
        case (ld_funct3_q)
            3'b000:  ld_data_d = {{(DATA_W-8){ld_byte[7]}}, ld_byte};
            3'b100:  ld_data_d = {{(DATA_W-8){1'b0}}, ld_byte};
            3'b001:  ld_data_d = {{(DATA_W-16){ld_half[15]}}, ld_half};
            3'b101:  ld_data_d = {{(DATA_W-16){1'b0}}, ld_half};
            default: ld_data_d = mem_rdata_i;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            rd_waddr_q  <= '0;
            rd_wdata_q  <= '0;
            rd_wen_q    <= 1'b0;
            retire_q    <= 1'b0;
            err_q       <= 1'b0;
            ld_rd_q     <= '0;
            ld_wen_q    <= 1'b0;
            ld_funct3_q <= 3'b000;
            ld_lsb_q    <= 2'b00;
        end else begin
            // Pulses default low; address and data hold until the next write.
            rd_wen_q <= 1'b0;
            retire_q <= 1'b0;
            err_q    <= 1'b0;
            case (state_q)
                S_IDLE, S_WB: begin
                    if (accept) begin
                        if (!in_is_load_i) begin
                            state_q    <= S_WB;
                            rd_waddr_q <= in_rd_addr_i;
                            rd_wdata_q <= in_alu_data_i;
                            rd_wen_q   <= in_rd_wen_i & (in_rd_addr_i != '0);
                            retire_q   <= 1'b1;
                        end else if (load_illegal) begin
                            state_q  <= S_WB;
                            err_q    <= 1'b1;
                            retire_q <= 1'b1;
                        end else begin
                            state_q     <= S_WAIT_MEM;
                            ld_rd_q     <= in_rd_addr_i;
                            ld_wen_q    <= in_rd_wen_i;
                            ld_funct3_q <= in_funct3_i;
                            ld_lsb_q    <= in_addr_lsb_i;
                        end
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                S_WAIT_MEM: begin
                    if (mem_rvalid_i) begin
                        state_q    <= S_WB;
                        rd_waddr_q <= ld_rd_q;
                        rd_wdata_q <= ld_data_d;
                        rd_wen_q   <= ld_wen_q & (ld_rd_q != '0);
                        retire_q   <= 1'b1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign rd_waddr_o = rd_waddr_q;
    assign rd_wdata_o = rd_wdata_q;
    assign rd_wen_o   = rd_wen_q;
    assign retire_o   = retire_q;
    assign err_o      = err_q;

endmodule

// File: tb/tb_wb_stage.sv
module tb_wb_stage;

  logic        clk;
  logic        rst;
  logic        in_valid_i;
  logic        in_ready_o;
  logic [4:0]  in_rd_addr_i;
  logic        in_rd_wen_i;
  logic        in_is_load_i;
  logic [2:0]  in_funct3_i;
  logic [1:0]  in_addr_lsb_i;
  logic [31:0] in_alu_data_i;
  logic        mem_rvalid_i;
  logic [31:0] mem_rdata_i;
  logic [4:0]  rd_waddr_o;
  logic [31:0] rd_wdata_o;
  logic        rd_wen_o;
  logic        retire_o;
  logic        err_o;
  logic [1:0]  dbg_state_o;

  int checks;
  int errors;
  logic [31:0] exp_q[$];

  wb_stage #(.DATA_W(32), .RADDR_W(5)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid_i   (in_valid_i),
    .in_ready_o   (in_ready_o),
    .in_rd_addr_i (in_rd_addr_i),
    .in_rd_wen_i  (in_rd_wen_i),
    .in_is_load_i (in_is_load_i),
    .in_funct3_i  (in_funct3_i),
    .in_addr_lsb_i(in_addr_lsb_i),
    .in_alu_data_i(in_alu_data_i),
    .mem_rvalid_i (mem_rvalid_i),
    .mem_rdata_i  (mem_rdata_i),
    .rd_waddr_o   (rd_waddr_o),
    .rd_wdata_o   (rd_wdata_o),
    .rd_wen_o     (rd_wen_o),
    .retire_o     (retire_o),
    .err_o        (err_o),
    .dbg_state_o  (dbg_state_o)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // check
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%08h exp=0x%08h t=%0t", tag, got, exp, $time);
    end
  endtask

  // driver tasks (inputs change on the falling edge, DUT samples on rising)
  task automatic clear_inputs();
    in_valid_i    = 1'b0;
    in_rd_addr_i  = 5'd0;
    in_rd_wen_i   = 1'b0;
    in_is_load_i  = 1'b0;
    in_funct3_i   = 3'b000;
    in_addr_lsb_i = 2'b00;
    in_alu_data_i = 32'h0;
    mem_rvalid_i  = 1'b0;
    mem_rdata_i   = 32'h0;
  endtask

  task automatic drive_alu(input logic [4:0] rd, input logic [31:0] data, input logic wen);
    in_valid_i    = 1'b1;
    in_is_load_i  = 1'b0;
    in_rd_addr_i  = rd;
    in_rd_wen_i   = wen;
    in_alu_data_i = data;
  endtask

  task automatic drive_load(input logic [4:0] rd, input logic [2:0] f3, input logic [1:0] lsb);
    in_valid_i    = 1'b1;
    in_is_load_i  = 1'b1;
    in_rd_addr_i  = rd;
    in_rd_wen_i   = 1'b1;
    in_funct3_i   = f3;
    in_addr_lsb_i = lsb;
  endtask

  // Load accepted on the next rising edge, data returned 'delay' cycles later.
  task automatic run_load(input string tag, input logic [2:0] f3, input logic [1:0] lsb,
                          input logic [31:0] rdata, input int delay, input logic [31:0] exp);
    drive_load(5'd7, f3, lsb);
    for (int i = 0; i < delay; i++) begin
      @(negedge clk);
      in_valid_i = 1'b0;
      check({tag, "_ready_wait"}, {31'd0, in_ready_o}, 32'd0);
    end
    mem_rvalid_i = 1'b1;
    mem_rdata_i  = rdata;
    @(negedge clk);
    mem_rvalid_i = 1'b0;
    check({tag, "_wen"},   {31'd0, rd_wen_o}, 32'd1);
    check({tag, "_waddr"}, {27'd0, rd_waddr_o}, 32'd7);
    check({tag, "_wdata"}, rd_wdata_o, exp);
    check({tag, "_retire"}, {31'd0, retire_o}, 32'd1);
    @(negedge clk);
    check({tag, "_wen_clr"}, {31'd0, rd_wen_o}, 32'd0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    clear_inputs();
    rst = 1'b1;
    #1;
    check("rst_waddr",  {27'd0, rd_waddr_o}, 32'd0);
    check("rst_wdata",  rd_wdata_o, 32'd0);
    check("rst_wen",    {31'd0, rd_wen_o}, 32'd0);
    check("rst_retire", {31'd0, retire_o}, 32'd0);
    check("rst_err",    {31'd0, err_o}, 32'd0);
    check("rst_ready",  {31'd0, in_ready_o}, 32'd1);
    check("rst_state",  {30'd0, dbg_state_o}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // ALU op, one cycle latency, pulse clears next cycle, data holds
    drive_alu(5'd5, 32'h1234_5678, 1'b1);
    @(negedge clk);
    in_valid_i = 1'b0;
    check("alu_wen",    {31'd0, rd_wen_o}, 32'd1);
    check("alu_waddr",  {27'd0, rd_waddr_o}, 32'd5);
    check("alu_wdata",  rd_wdata_o, 32'h1234_5678);
    check("alu_retire", {31'd0, retire_o}, 32'd1);
    check("alu_state",  {30'd0, dbg_state_o}, 32'd2);
    @(negedge clk);
    check("alu_wen_clr",    {31'd0, rd_wen_o}, 32'd0);
    check("alu_retire_clr", {31'd0, retire_o}, 32'd0);
    check("alu_wdata_hold", rd_wdata_o, 32'h1234_5678);

    // loads with alignment / extension
    run_load("lb3",  3'b000, 2'd3, 32'h80FF_0000, 3, 32'hFFFF_FF80);
    run_load("lbu3", 3'b100, 2'd3, 32'h80FF_0000, 3, 32'h0000_0080);
    run_load("lh2",  3'b001, 2'd2, 32'h8001_7FFF, 2, 32'hFFFF_8001);
    run_load("lhu0", 3'b101, 2'd0, 32'h8001_7FFF, 1, 32'h0000_7FFF);
    run_load("lw0",  3'b010, 2'd0, 32'hDEAD_BEEF, 1, 32'hDEAD_BEEF);

    // misaligned LH: error one cycle after accept, no memory wait
    drive_load(5'd8, 3'b001, 2'd1);
    @(negedge clk);
    in_valid_i = 1'b0;
    check("lh1_err",    {31'd0, err_o}, 32'd1);
    check("lh1_wen",    {31'd0, rd_wen_o}, 32'd0);
    check("lh1_retire", {31'd0, retire_o}, 32'd1);
    check("lh1_ready",  {31'd0, in_ready_o}, 32'd1);
    @(negedge clk);
    check("lh1_err_clr", {31'd0, err_o}, 32'd0);

    // illegal funct3
    drive_load(5'd8, 3'b111, 2'd0);
    @(negedge clk);
    in_valid_i = 1'b0;
    check("f3ill_err", {31'd0, err_o}, 32'd1);
    check("f3ill_wen", {31'd0, rd_wen_o}, 32'd0);
    @(negedge clk);

    // back-to-back ALU ops with in_valid_i held high
    exp_q.push_back(32'h0000_0011);
    exp_q.push_back(32'h0000_0022);
    exp_q.push_back(32'h0000_0033);
    drive_alu(5'd1, 32'h0000_0011, 1'b1);
    for (int i = 1; i <= 3; i++) begin
      logic [31:0] exp_d;
      @(negedge clk);
      if (i < 3) drive_alu(5'(i + 1), 32'(17 * (i + 1)), 1'b1);
      else       in_valid_i = 1'b0;
      exp_d = exp_q.pop_front();
      check("b2b_wen",   {31'd0, rd_wen_o}, 32'd1);
      check("b2b_waddr", {27'd0, rd_waddr_o}, 32'(i));
      check("b2b_wdata", rd_wdata_o, exp_d);
    end
    @(negedge clk);
    check("b2b_wen_clr", {31'd0, rd_wen_o}, 32'd0);

    // destination x0
    drive_alu(5'd0, 32'hCAFE_0000, 1'b1);
    @(negedge clk);
    in_valid_i = 1'b0;
    check("x0_retire", {31'd0, retire_o}, 32'd1);
    check("x0_wen",    {31'd0, rd_wen_o}, 32'd0);
    @(negedge clk);

    // stray rvalid in IDLE
    mem_rvalid_i = 1'b1;
    mem_rdata_i  = 32'h5555_AAAA;
    @(negedge clk);
    mem_rvalid_i = 1'b0;
    check("stray_wen",    {31'd0, rd_wen_o}, 32'd0);
    check("stray_retire", {31'd0, retire_o}, 32'd0);
    check("stray_state",  {30'd0, dbg_state_o}, 32'd0);

    // reset during WAIT_MEM: asynchronous clear, later rvalid ignored
    drive_alu(5'd6, 32'hA5A5_A5A5, 1'b1);
    @(negedge clk);
    drive_load(5'd9, 3'b010, 2'd0);
    @(negedge clk);
    in_valid_i = 1'b0;
    check("rstw_ready_pre", {31'd0, in_ready_o}, 32'd0);
    check("rstw_waddr_pre", {27'd0, rd_waddr_o}, 32'd6);
    #2;
    rst = 1'b1;
    #1;
    check("rstw_waddr", {27'd0, rd_waddr_o}, 32'd0);
    check("rstw_wdata", rd_wdata_o, 32'd0);
    check("rstw_ready", {31'd0, in_ready_o}, 32'd1);
    @(negedge clk);
    rst = 1'b0;
    mem_rvalid_i = 1'b1;
    mem_rdata_i  = 32'h1111_2222;
    @(negedge clk);
    mem_rvalid_i = 1'b0;
    check("rstw_late_wen",    {31'd0, rd_wen_o}, 32'd0);
    check("rstw_late_retire", {31'd0, retire_o}, 32'd0);
    check("rstw_late_wdata",  rd_wdata_o, 32'd0);

    // final report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
